// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared parameters and types for the write-back arbiter
package wb_write_arbiter_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_PIPE  = 2'd1,
    SRC_QUEUE = 2'd2
  } wr_src_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - pipeline, multi-cycle, register-file and hazard-query signals
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              mcu_valid;
  logic              mcu_ready;
  logic [ADDR_W-1:0] mcu_waddr;
  logic [DATA_W-1:0] mcu_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] q_raddr1;
  logic              q_pend1;
  logic [ADDR_W-1:0] q_raddr2;
  logic              q_pend2;
  logic [CNT_W-1:0]  q_count;

  modport master (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  mcu_valid, mcu_waddr, mcu_wdata,
    output mcu_ready,
    output we, waddr, wdata,
    input  q_raddr1, q_raddr2,
    output q_pend1, q_pend2, q_count
  );

  modport slave (
    output pipe_we, pipe_waddr, pipe_wdata,
    output mcu_valid, mcu_waddr, mcu_wdata,
    input  mcu_ready,
    input  we, waddr, wdata,
    output q_raddr1, q_raddr2,
    input  q_pend1, q_pend2, q_count
  );

endinterface

// File: rtl/wb_write_arbiter_queue.sv
// rtl/wb_write_arbiter_queue.sv - circular result queue with WAW squash and hazard lookup
module wb_write_arbiter_queue
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         squash,
  input  logic [ADDR_W-1:0]            squash_addr,
  output logic                         head_valid,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [ADDR_W-1:0]            raddr1,
  output logic                         pend1,
  input  logic [ADDR_W-1:0]            raddr2,
  output logic                         pend2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_valid = valid_q[rd_ptr];
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  // Valid bits are only ever set on occupied slots, so lookups can scan every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && addr_q[i] == squash_addr) valid_q[i] <= 1'b0;
      end
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      // A same-cycle push to the squashed address is newer, so it lands after the squash.
      if (do_push) begin
        valid_q[wr_ptr] <= 1'b1;
        addr_q[wr_ptr]  <= push_addr;
        data_q[wr_ptr]  <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == raddr1) pend1 = 1'b1;
      if (valid_q[i] && addr_q[i] == raddr2) pend2 = 1'b1;
    end
    if (raddr1 == '0) pend1 = 1'b0;
    if (raddr2 == '0) pend2 = 1'b0;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and multi-cycle results onto the register-file write port
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.master bus
);
  logic              ready_en;
  logic              pipe_hit;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              full;
  logic              empty;
  wr_src_e           src;

  // ready_en keeps mcu_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign bus.mcu_ready = ready_en && !full;
  assign pipe_hit      = bus.pipe_we && (bus.pipe_waddr != '0);
  assign push          = bus.mcu_valid && bus.mcu_ready && (bus.mcu_waddr != '0);
  assign pop           = (src == SRC_QUEUE);

  always_comb begin
    src = SRC_NONE;
    if (pipe_hit)    src = SRC_PIPE;
    else if (!empty) src = SRC_QUEUE;
  end

  wb_write_arbiter_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (bus.mcu_waddr),
    .push_data   (bus.mcu_wdata),
    .pop         (pop),
    .squash      (pipe_hit),
    .squash_addr (bus.pipe_waddr),
    .head_valid  (head_valid),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .count       (bus.q_count),
    .raddr1      (bus.q_raddr1),
    .pend1       (bus.q_pend1),
    .raddr2      (bus.q_raddr2),
    .pend2       (bus.q_pend2)
  );

  // A squashed head still pops but produces no write; address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      case (src)
        SRC_PIPE: begin
          bus.we    <= 1'b1;
          bus.waddr <= bus.pipe_waddr;
          bus.wdata <= bus.pipe_wdata;
        end
        SRC_QUEUE: begin
          bus.we <= head_valid;
          if (head_valid) begin
            bus.waddr <= head_addr;
            bus.wdata <= head_data;
          end
        end
        default: bus.we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed and scoreboard bench for wb_write_arbiter
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d);
    check({tag, "_we"}, bus.we, e_we);
    check({tag, "_addr"}, bus.waddr, e_a);
    check({tag, "_data"}, bus.wdata, e_d);
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.pipe_we    = pw;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.mcu_valid  = mv;
    bus.mcu_waddr  = ma;
    bus.mcu_wdata  = md;
  endtask

  logic [4:0]  qa [$];
  logic [31:0] qd [$];
  logic        qv [$];
  int          pushed;
  logic        pending, acc, exp_ready, exp_we;
  logic        pw, mv;
  logic [4:0]  pa, ma, exp_a;
  logic [31:0] pd, md, exp_d;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus.q_raddr1 = 0;
    bus.q_raddr2 = 0;

    // 1: reset values, then asynchronous reset while draining
    repeat (2) @(posedge clk);
    #1;
    check_wr("t1_rst", 0, 0, 0);
    check("t1_rst_count", bus.q_count, 0);
    check("t1_rst_ready", bus.mcu_ready, 0);
    rst = 1'b0;
    tick();
    check("t1_ready_up", bus.mcu_ready, 1);
    drive(1, 1, 32'h100, 1, 10, 32'hA0); tick();
    drive(1, 1, 32'h100, 1, 11, 32'hA1); tick();
    drive(1, 1, 32'h100, 1, 12, 32'hA2); tick();
    bus.mcu_valid = 0;
    bus.q_raddr1  = 11;
    #1;
    check("t1_fill_count", bus.q_count, 3);
    check("t1_fill_pend", bus.q_pend1, 1);
    bus.pipe_we = 0;
    tick();
    check_wr("t1_drain", 1, 10, 32'hA0);
    check("t1_drain_count", bus.q_count, 2);
    #2 rst = 1'b1;
    #1;
    check("t1_async_we", bus.we, 0);
    check("t1_async_count", bus.q_count, 0);
    check("t1_async_pend", bus.q_pend1, 0);
    check("t1_async_ready", bus.mcu_ready, 0);
    #1 rst = 1'b0;
    tick();
    check("t1_rel_ready", bus.mcu_ready, 1);
    check("t1_rel_count", bus.q_count, 0);

    // 2: pipeline priority over a queued result
    drive(1, 7, 32'h1, 1, 5, 32'hAAAA); tick();
    check_wr("t2_r7", 1, 7, 32'h1);
    drive(1, 8, 32'h2, 0, 0, 0); tick();
    check_wr("t2_r8", 1, 8, 32'h2);
    bus.pipe_we = 0;
    tick();
    check_wr("t2_r5", 1, 5, 32'hAAAA);
    check("t2_count", bus.q_count, 0);

    // 3: full backpressure, then one pop per cycle with a simultaneous push
    drive(1, 1, 32'h55, 1, 16, 32'h1010);
    for (int c = 0; c < 6; c++) begin
      #1 check($sformatf("t3_ready_c%0d", c), bus.mcu_ready, (c < 4));
      tick();
      if (c < 4) begin
        bus.mcu_waddr = 5'(17 + c);
        bus.mcu_wdata = 32'h1000 + 32'(17 + c);
      end
    end
    check("t3_full_count", bus.q_count, 4);
    bus.q_raddr2 = 17;
    #1 check("t3_pend17", bus.q_pend2, 1);
    bus.q_raddr2 = 20;
    #1 check("t3_pend20", bus.q_pend2, 0);
    bus.pipe_we = 0;
    tick();
    check_wr("t3_pop16", 1, 16, 32'h1010);
    check("t3_pop16_count", bus.q_count, 3);
    check("t3_ready_back", bus.mcu_ready, 1);
    tick();
    check_wr("t3_pop17", 1, 17, 32'h1011);
    check("t3_pushpop_count", bus.q_count, 3);
    bus.mcu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_wr($sformatf("t3_pop%0d", 18 + k), 1, 5'(18 + k), 32'h1012 + 32'(k));
      check($sformatf("t3_count%0d", k), bus.q_count, 2 - k);
    end
    tick();
    check_wr("t3_idle", 0, 20, 32'h1014);

    // 4: WAW squash, and a same-cycle push that must survive
    drive(1, 2, 32'h2, 1, 9, 32'h11); tick();
    drive(1, 9, 32'h22, 0, 0, 0);
    bus.q_raddr1 = 9;
    #1 check("t4_pend_before", bus.q_pend1, 1);
    tick();
    check_wr("t4_pipe", 1, 9, 32'h22);
    check("t4_pend_after", bus.q_pend1, 0);
    check("t4_squash_count", bus.q_count, 1);
    bus.pipe_we = 0;
    tick();
    check_wr("t4_squashed_pop", 0, 9, 32'h22);
    check("t4_empty", bus.q_count, 0);
    drive(1, 9, 32'h44, 1, 9, 32'h55); tick();
    check_wr("t4_same_pipe", 1, 9, 32'h44);
    check("t4_same_pend", bus.q_pend1, 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    check_wr("t4_same_pop", 1, 9, 32'h55);

    // 5: writes to register 0
    drive(1, 4, 32'h4, 1, 3, 32'h33); tick();
    drive(1, 0, 32'hDEAD, 0, 0, 0); tick();
    check_wr("t5_r0_pipe", 1, 3, 32'h33);
    drive(0, 0, 0, 1, 0, 32'h77);
    #1 check("t5_r0_ready", bus.mcu_ready, 1);
    tick();
    check("t5_r0_count", bus.q_count, 0);
    check("t5_r0_we", bus.we, 0);
    bus.mcu_valid = 0;

    // 6: random traffic against a queue model
    pushed  = 0;
    pending = 0;
    mv = 0; ma = 0; md = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pushed >= 3 * DEPTH + 1 && !pending && qa.size() == 0) break;
      if (!pending) begin
        mv = (pushed < 3 * DEPTH + 1) && ($urandom_range(3) != 0);
        ma = 5'($urandom_range(7));
        md = $urandom;
      end
      pw = 1'($urandom_range(1));
      pa = 5'($urandom_range(7));
      pd = $urandom;
      drive(pw, pa, pd, mv, ma, md);
      #1;
      exp_ready = (qa.size() < DEPTH);
      check("t6_ready", bus.mcu_ready, exp_ready);
      acc = mv && exp_ready;
      exp_we = 0;
      if (pw && pa != 0) begin
        exp_we = 1; exp_a = pa; exp_d = pd;
        for (int i = 0; i < qa.size(); i++) if (qa[i] == pa) qv[i] = 0;
      end else if (qa.size() > 0) begin
        exp_we = qv[0]; exp_a = qa[0]; exp_d = qd[0];
        void'(qa.pop_front()); void'(qd.pop_front()); void'(qv.pop_front());
      end
      if (acc && ma != 0) begin
        qa.push_back(ma); qd.push_back(md); qv.push_back(1'b1);
      end
      tick();
      check("t6_we", bus.we, exp_we);
      if (exp_we) begin
        check("t6_waddr", bus.waddr, exp_a);
        check("t6_wdata", bus.wdata, exp_d);
      end
      check("t6_count", bus.q_count, qa.size());
      pending = mv && !acc;
      if (acc) pushed++;
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t6_drained", bus.q_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
